pulp_pwr_seq_ctrl: RTL and testbench

- Always-on sequencer for one switchable power domain: orders clock gating, isolation, retention save/restore and power-switch control on power-down and power-up requests.
- Its control outputs feed the domain-crossing output level shifters.
- Its pwr_good_i input arrives from the switched domain's power-good monitor.

---
 rtl/pulp_pwr_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_pulp_pwr_seq_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulp_pwr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pulp_pwr_seq_ctrl
//
// Always-on power sequencer for one switchable power domain. On a power-down
// request it gates the domain clock, clamps the isolation cells, pulses a
// retention save and opens the power switch. On a power-up request it closes
// the switch, waits for the supply to be good, pulses a retention restore,
// releases isolation and finally re-enables the clock.
//
// The sequence guarantees at all times:
//   clk_en_o = 1  ->  iso_en_o = 0 and pwr_sw_en_o = 1
//   pwr_sw_en_o = 0  ->  iso_en_o = 1
//
// Ports:
//   clk_i          always-on clock
//   rst_i          synchronous reset, active-high
//   pwr_off_req_i  level power-down request, only looked at in ON
//   pwr_on_req_i   level power-up request, only looked at in OFF
//   pwr_good_i     supply-valid from the domain monitor (already synchronised)
//   err_clr_i      clears the sticky timeout flag
//   clk_en_o       domain clock enable
//   iso_en_o       isolation clamp enable
//   ret_save_o     one-cycle retention save pulse
//   ret_restore_o  one-cycle retention restore pulse
//   pwr_sw_en_o    power switch enable
//   busy_o         high while a sequence is in progress
//   done_o         one-cycle pulse when ON or OFF is reached by a sequence
//   err_o          sticky pwr_good_i timeout flag
//   state_o        current state encoding (debug)
//
// Parameters:
//   SETTLE_CYCLES   cycles in CLK_GATE, ISO_ON and ISO_REL (1..255)
//   TIMEOUT_CYCLES  max cycles waiting for pwr_good_i (1..65535)
//   RESET_ON        1: reset into ON (powered), 0: reset into OFF
// -----------------------------------------------------------------------------
module pulp_pwr_seq_ctrl #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          RESET_ON       = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pwr_off_req_i,
    input  logic       pwr_on_req_i,
    input  logic       pwr_good_i,
    input  logic       err_clr_i,
    output logic       clk_en_o,
    output logic       iso_en_o,
    output logic       ret_save_o,
    output logic       ret_restore_o,
    output logic       pwr_sw_en_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        ST_ON         = 4'd0,
        ST_CLK_GATE   = 4'd1,
        ST_ISO_ON     = 4'd2,
        ST_SAVE       = 4'd3,
        ST_PSW_OFF    = 4'd4,
        ST_OFF        = 4'd5,
        ST_PSW_ON     = 4'd6,
        ST_RESTORE    = 4'd7,
        ST_ISO_REL    = 4'd8,
        ST_CLK_UNGATE = 4'd9
    } state_e;

    localparam state_e RST_STATE = RESET_ON ? ST_ON : ST_OFF;

    // The counter holds "cycles remaining after this one", so a state that
    // must last N cycles is entered with N-1 and left when the counter is 0.
    localparam logic [15:0] SETTLE_LOAD  = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES - 1);

    // Down-count that sticks at zero instead of wrapping.
    function automatic logic [15:0] cnt_sat_dec(input logic [15:0] cnt);
        cnt_sat_dec = (cnt == 16'd0) ? 16'd0 : cnt - 16'd1;
    endfunction

    // Value loaded into the wait counter when a state is entered.
    function automatic logic [15:0] cnt_reload(input state_e st);
        case (st)
            ST_CLK_GATE,
            ST_ISO_ON,
            ST_ISO_REL:  cnt_reload = SETTLE_LOAD;
            ST_PSW_OFF,
            ST_PSW_ON:   cnt_reload = TIMEOUT_LOAD;
            default:     cnt_reload = 16'd0;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        clk_en_q, clk_en_d;
    logic        iso_en_q, iso_en_d;
    logic        ret_save_q, ret_save_d;
    logic        ret_restore_q, ret_restore_d;
    logic        pwr_sw_en_q, pwr_sw_en_d;
    logic        busy_q, busy_d;
    logic        timeout;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            ST_ON: begin
                if (pwr_off_req_i) state_d = ST_CLK_GATE;
            end
            ST_CLK_GATE: begin
                if (cnt_q == 16'd0) state_d = ST_ISO_ON;
            end
            ST_ISO_ON: begin
                if (cnt_q == 16'd0) state_d = ST_SAVE;
            end
            ST_SAVE: begin
                state_d = ST_PSW_OFF;
            end
            ST_PSW_OFF: begin
                if (!pwr_good_i) begin
                    state_d = ST_OFF;
                end else if (cnt_q == 16'd0) begin
                    state_d = ST_OFF;
                    timeout = 1'b1;
                end
            end
            ST_OFF: begin
                if (pwr_on_req_i) state_d = ST_PSW_ON;
            end
            ST_PSW_ON: begin
                // A supply that never comes up aborts back to OFF with the
                // switch re-opened; the restore pulse is skipped entirely.
                if (pwr_good_i) begin
                    state_d = ST_RESTORE;
                end else if (cnt_q == 16'd0) begin
                    state_d = ST_OFF;
                    timeout = 1'b1;
                end
            end
            ST_RESTORE: begin
                state_d = ST_ISO_REL;
            end
            ST_ISO_REL: begin
                if (cnt_q == 16'd0) state_d = ST_CLK_UNGATE;
            end
            ST_CLK_UNGATE: begin
                state_d = ST_ON;
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    // Counter, event flags and registered Moore outputs
    always_comb begin
        cnt_d = (state_d != state_q) ? cnt_reload(state_d) : cnt_sat_dec(cnt_q);

        // A timeout in the same cycle as a clear keeps the flag set.
        if (timeout) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        done_d = (state_d != state_q) && ((state_d == ST_ON) || (state_d == ST_OFF));
        busy_d = (state_d != ST_ON) && (state_d != ST_OFF);

        // Outputs are a function of the next state so that they change on the
        // same edge the state does.
        clk_en_d      = 1'b0;
        iso_en_d      = 1'b1;
        pwr_sw_en_d   = 1'b1;
        ret_save_d    = 1'b0;
        ret_restore_d = 1'b0;
        case (state_d)
            ST_ON: begin
                clk_en_d = 1'b1;
                iso_en_d = 1'b0;
            end
            ST_CLK_GATE,
            ST_ISO_REL,
            ST_CLK_UNGATE: begin
                iso_en_d = 1'b0;
            end
            ST_SAVE: begin
                ret_save_d = 1'b1;
            end
            ST_PSW_OFF,
            ST_OFF: begin
                pwr_sw_en_d = 1'b0;
            end
            ST_RESTORE: begin
                ret_restore_d = 1'b1;
            end
            default: begin
                // ISO_ON, PSW_ON: clamped, switch closed, clock gated.
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= RST_STATE;
            cnt_q         <= 16'd0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            clk_en_q      <= RESET_ON;
            iso_en_q      <= !RESET_ON;
            pwr_sw_en_q   <= RESET_ON;
            ret_save_q    <= 1'b0;
            ret_restore_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            clk_en_q      <= clk_en_d;
            iso_en_q      <= iso_en_d;
            pwr_sw_en_q   <= pwr_sw_en_d;
            ret_save_q    <= ret_save_d;
            ret_restore_q <= ret_restore_d;
        end
    end

    assign clk_en_o      = clk_en_q;
    assign iso_en_o      = iso_en_q;
    assign ret_save_o    = ret_save_q;
    assign ret_restore_o = ret_restore_q;
    assign pwr_sw_en_o   = pwr_sw_en_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_pulp_pwr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for pulp_pwr_seq_ctrl. Instance "dut" resets into ON and carries
// the directed sequences; instance "dut_b" resets into OFF and shares the same
// inputs. Both are checked for the output invariants on every cycle.
// -----------------------------------------------------------------------------
module tb_pulp_pwr_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, off_req, on_req, good, err_clr;

    logic       a_clk, a_iso, a_save, a_restore, a_psw, a_busy, a_done, a_err;
    logic [3:0] a_state;
    logic       b_clk, b_iso, b_save, b_restore, b_psw, b_busy, b_done, b_err;
    logic [3:0] b_state;

    pulp_pwr_seq_ctrl #(
        .SETTLE_CYCLES (4),
        .TIMEOUT_CYCLES(10),
        .RESET_ON      (1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .pwr_off_req_i(off_req),
        .pwr_on_req_i (on_req),
        .pwr_good_i   (good),
        .err_clr_i    (err_clr),
        .clk_en_o     (a_clk),
        .iso_en_o     (a_iso),
        .ret_save_o   (a_save),
        .ret_restore_o(a_restore),
        .pwr_sw_en_o  (a_psw),
        .busy_o       (a_busy),
        .done_o       (a_done),
        .err_o        (a_err),
        .state_o      (a_state)
    );

    pulp_pwr_seq_ctrl #(
        .SETTLE_CYCLES (4),
        .TIMEOUT_CYCLES(10),
        .RESET_ON      (1'b0)
    ) dut_b (
        .clk_i        (clk),
        .rst_i        (rst),
        .pwr_off_req_i(off_req),
        .pwr_on_req_i (on_req),
        .pwr_good_i   (good),
        .err_clr_i    (err_clr),
        .clk_en_o     (b_clk),
        .iso_en_o     (b_iso),
        .ret_save_o   (b_save),
        .ret_restore_o(b_restore),
        .pwr_sw_en_o  (b_psw),
        .busy_o       (b_busy),
        .done_o       (b_done),
        .err_o        (b_err),
        .state_o      (b_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int restore_cnt = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge and the
    // invariants of both instances are checked every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        chk1("inv_a_clk", a_clk & (a_iso | ~a_psw), 1'b0);
        chk1("inv_a_psw", ~a_psw & ~a_iso, 1'b0);
        chk1("inv_b_clk", b_clk & (b_iso | ~b_psw), 1'b0);
        chk1("inv_b_psw", ~b_psw & ~b_iso, 1'b0);
        if (a_restore) restore_cnt++;
    endtask

    task automatic wait_state(input string tag, input logic [3:0] exp, input int max);
        int n = 0;
        while (a_state !== exp && n < max) begin
            tick();
            n++;
        end
        chk4(tag, a_state, exp);
    endtask

    // Power-down timeline, cycles 1..12 after the request edge.
    int         st1 [1:12] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 4, 4, 5};
    logic [12:1] e1_iso  = 12'b1111_1111_0000;
    logic [12:1] e1_save = 12'b0001_0000_0000;
    logic [12:1] e1_psw  = 12'b0001_1111_1111;
    logic [12:1] e1_busy = 12'b0111_1111_1111;
    logic [12:1] e1_done = 12'b1000_0000_0000;

    // Power-up timeline, cycles 0..10 after the request edge.
    int         st2 [0:10] = '{6, 6, 6, 6, 7, 8, 8, 8, 8, 9, 0};
    logic [10:0] e2_iso  = 11'b000_0001_1111;
    logic [10:0] e2_rest = 11'b000_0001_0000;
    logic [10:0] e2_clk  = 11'b100_0000_0000;
    logic [10:0] e2_done = 11'b100_0000_0000;
    logic [10:0] e2_busy = 11'b011_1111_1111;

    initial begin
        rst = 1'b1; off_req = 1'b0; on_req = 1'b0; good = 1'b1; err_clr = 1'b0;
        repeat (3) tick();

        // Reset state of both instances
        chk4("rst_a_state", a_state, 4'd0);
        chk1("rst_a_clk",   a_clk,   1'b1);
        chk1("rst_a_iso",   a_iso,   1'b0);
        chk1("rst_a_psw",   a_psw,   1'b1);
        chk1("rst_a_save",  a_save,  1'b0);
        chk1("rst_a_rest",  a_restore, 1'b0);
        chk1("rst_a_busy",  a_busy,  1'b0);
        chk1("rst_a_done",  a_done,  1'b0);
        chk1("rst_a_err",   a_err,   1'b0);
        chk4("rst_b_state", b_state, 4'd5);
        chk1("rst_b_clk",   b_clk,   1'b0);
        chk1("rst_b_iso",   b_iso,   1'b1);
        chk1("rst_b_psw",   b_psw,   1'b0);
        chk1("rst_b_busy",  b_busy,  1'b0);
        chk1("rst_b_done",  b_done,  1'b0);
        rst = 1'b0;
        tick();
        chk4("idle_a_state", a_state, 4'd0);

        // Power-down, pwr_good drops one cycle after the switch opens
        off_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1)  off_req = 1'b0;
            if (c == 11) good = 1'b0;
            chk4($sformatf("dn_state_c%0d", c), a_state, 4'(st1[c]));
            chk1($sformatf("dn_clk_c%0d", c),   a_clk,   1'b0);
            chk1($sformatf("dn_iso_c%0d", c),   a_iso,   e1_iso[c]);
            chk1($sformatf("dn_save_c%0d", c),  a_save,  e1_save[c]);
            chk1($sformatf("dn_psw_c%0d", c),   a_psw,   e1_psw[c]);
            chk1($sformatf("dn_busy_c%0d", c),  a_busy,  e1_busy[c]);
            chk1($sformatf("dn_done_c%0d", c),  a_done,  e1_done[c]);
        end

        // Power-up, pwr_good rises 3 cycles after the switch closes
        restore_cnt = 0;
        on_req = 1'b1;
        for (int p = 0; p <= 10; p++) begin
            tick();
            if (p == 0) on_req = 1'b0;
            if (p == 3) good = 1'b1;
            chk4($sformatf("up_state_p%0d", p), a_state, 4'(st2[p]));
            chk1($sformatf("up_clk_p%0d", p),   a_clk,   e2_clk[p]);
            chk1($sformatf("up_iso_p%0d", p),   a_iso,   e2_iso[p]);
            chk1($sformatf("up_rest_p%0d", p),  a_restore, e2_rest[p]);
            chk1($sformatf("up_psw_p%0d", p),   a_psw,   1'b1);
            chk1($sformatf("up_busy_p%0d", p),  a_busy,  e2_busy[p]);
            chk1($sformatf("up_done_p%0d", p),  a_done,  e2_done[p]);
        end
        chkn("up_restore_count", restore_cnt, 1);

        // Power down again, then power up with pwr_good stuck low
        off_req = 1'b1;
        tick();
        off_req = 1'b0;
        good = 1'b0;
        wait_state("down2_off", 4'd5, 30);
        chk1("down2_done", a_done, 1'b1);

        restore_cnt = 0;
        on_req = 1'b1;
        for (int t = 0; t <= 10; t++) begin
            tick();
            if (t == 0) on_req = 1'b0;
            if (t < 10) begin
                chk4($sformatf("to_state_t%0d", t), a_state, 4'd6);
                chk1($sformatf("to_err_t%0d", t),   a_err,   1'b0);
            end
        end
        chk4("to_state_end", a_state, 4'd5);
        chk1("to_err_end",   a_err,   1'b1);
        chk1("to_psw_end",   a_psw,   1'b0);
        chk1("to_done_end",  a_done,  1'b1);
        chk1("to_busy_end",  a_busy,  1'b0);
        chkn("to_no_restore", restore_cnt, 0);
        err_clr = 1'b1;
        tick();
        chk1("err_cleared", a_err, 1'b0);

        // Timeout coinciding with err_clr: the timeout wins
        on_req = 1'b1;
        tick();
        on_req = 1'b0;
        repeat (9) tick();
        chk1("tw_err_before", a_err, 1'b0);
        tick();
        chk4("tw_state", a_state, 4'd5);
        chk1("tw_err_set", a_err, 1'b1);
        err_clr = 1'b0;
        tick();
        chk1("tw_err_sticky", a_err, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk1("tw_err_clr", a_err, 1'b0);

        // pwr_good already high: PSW_ON lasts one cycle
        good = 1'b1;
        on_req = 1'b1;
        tick();
        on_req = 1'b0;
        chk4("fast_psw_on", a_state, 4'd6);
        tick();
        chk4("fast_restore", a_state, 4'd7);
        wait_state("up3_on", 4'd0, 30);
        chk1("up3_done", a_done, 1'b1);

        // On-request during CLK_GATE is ignored
        off_req = 1'b1;
        tick();
        off_req = 1'b0;
        on_req = 1'b1;
        tick();
        chk4("ign_on_c2", a_state, 4'd1);
        on_req = 1'b0;
        tick();
        chk4("ign_on_c3", a_state, 4'd1);
        good = 1'b0;
        wait_state("ign_off", 4'd5, 30);
        tick();
        tick();
        chk4("ign_stay_off", a_state, 4'd5);

        // Both requests in ON: power-down wins
        good = 1'b1;
        on_req = 1'b1;
        tick();
        on_req = 1'b0;
        wait_state("both_up", 4'd0, 30);
        off_req = 1'b1;
        on_req = 1'b1;
        tick();
        off_req = 1'b0;
        on_req = 1'b0;
        chk4("both_clk_gate", a_state, 4'd1);
        good = 1'b0;
        wait_state("both_off", 4'd5, 30);
        chk1("both_done", a_done, 1'b1);

        // Reset in PSW_ON with err set
        on_req = 1'b1;
        tick();
        on_req = 1'b0;
        wait_state("pre_rst_to", 4'd5, 30);
        chk1("pre_rst_err", a_err, 1'b1);
        on_req = 1'b1;
        tick();
        on_req = 1'b0;
        tick();
        chk4("pre_rst_psw_on", a_state, 4'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk4("rst_psw_state", a_state, 4'd0);
        chk1("rst_psw_clk",   a_clk,   1'b1);
        chk1("rst_psw_iso",   a_iso,   1'b0);
        chk1("rst_psw_psw",   a_psw,   1'b1);
        chk1("rst_psw_done",  a_done,  1'b0);
        chk1("rst_psw_err",   a_err,   1'b0);
        chk1("rst_psw_busy",  a_busy,  1'b0);
        chk1("rst_psw_rest",  a_restore, 1'b0);
        tick();
        chk1("rst_psw_done2", a_done, 1'b0);
        chk4("rst_psw_state2", a_state, 4'd0);

        // Reset in ISO_ON, then a full-length settle afterwards
        good = 1'b1;
        off_req = 1'b1;
        tick();
        off_req = 1'b0;
        repeat (4) tick();
        chk4("pre_rst_iso_on", a_state, 4'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk4("rst_iso_state", a_state, 4'd0);
        chk1("rst_iso_clk",   a_clk,   1'b1);
        chk1("rst_iso_iso",   a_iso,   1'b0);
        chk1("rst_iso_psw",   a_psw,   1'b1);
        chk1("rst_iso_done",  a_done,  1'b0);
        chk1("rst_iso_busy",  a_busy,  1'b0);
        off_req = 1'b1;
        tick();
        off_req = 1'b0;
        repeat (3) tick();
        chk4("post_rst_c4", a_state, 4'd1);
        tick();
        chk4("post_rst_c5", a_state, 4'd2);

        // Randomised traffic; invariants are checked inside tick()
        for (int i = 0; i < 10000; i++) begin
            rst     = ($urandom_range(0, 299) == 0);
            off_req = ($urandom_range(0, 7) == 0);
            on_req  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) good = ~good;
            err_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        rst = 1'b1; off_req = 1'b0; on_req = 1'b0; err_clr = 1'b0;
        tick();
        rst = 1'b0;
        chk4("final_rst_a", a_state, 4'd0);
        chk4("final_rst_b", b_state, 4'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
